// File: rtl/rdi_multi_timer_if.sv
// Bundle of per-channel control and status signals for rdi_multi_timer.
//   i_en          per-channel run level (0 clears the channel)
//   i_hold        per-channel freeze while enabled
//   i_limit       packed limits, channel c at [c*CNT_W +: CNT_W]
//   o_timeout     per-channel timeout (pulse or sticky)
//   o_timeout_any OR of o_timeout
//   o_busy        per-channel RUN indication
//   o_count       packed current counters, same packing as i_limit
// Modports: master = RDI controller side, slave = timer side.
interface rdi_multi_timer_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 12
);
    logic [NUM_CH-1:0]       i_en;
    logic [NUM_CH-1:0]       i_hold;
    logic [NUM_CH*CNT_W-1:0] i_limit;
    logic [NUM_CH-1:0]       o_timeout;
    logic                    o_timeout_any;
    logic [NUM_CH-1:0]       o_busy;
    logic [NUM_CH*CNT_W-1:0] o_count;

    modport master (
        output i_en, i_hold, i_limit,
        input  o_timeout, o_timeout_any, o_busy, o_count
    );

    modport slave (
        input  i_en, i_hold, i_limit,
        output o_timeout, o_timeout_any, o_busy, o_count
    );
endinterface

// File: rtl/rdi_multi_timer.sv
// Multi-channel timeout engine beside the RDI state machine. Each channel counts enabled,
// unheld edges up to a limit captured at start (and at each pulse-mode restart), then either
// emits a one-cycle pulse and restarts (pulse mode) or latches its timeout until i_en drops
// (sticky mode, selected per channel by STICKY_MASK).
// Ports:
//   lclk     RDI clock, rising edge
//   sys_rst  asynchronous active-high reset
//   bus      rdi_multi_timer_if slave: i_en/i_hold/i_limit in, o_timeout/o_timeout_any/
//            o_busy/o_count out
module rdi_multi_timer #(
    parameter int                NUM_CH      = 2,
    parameter int                CNT_W       = 12,
    parameter logic [NUM_CH-1:0] STICKY_MASK = 2'b10
) (
    input logic                lclk,
    input logic                sys_rst,
    rdi_multi_timer_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q  [NUM_CH];
    state_e            state_d  [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [NUM_CH-1:0] timeout_q;
    logic [NUM_CH-1:0] timeout_d;

    // State register (includes the per-channel datapath registers).
    always_ff @(posedge lclk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= StIdle;
                count_q[c]  <= '0;
                shadow_q[c] <= '0;
            end
            timeout_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                count_q[c]  <= count_d[c];
                shadow_q[c] <= shadow_d[c];
            end
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        logic [CNT_W-1:0] lim_in;
        logic [CNT_W-1:0] lim_eff;
        logic [CNT_W-1:0] cnt_inc;
        logic             advance;
        lim_in    = '0;
        lim_eff   = '0;
        cnt_inc   = '0;
        advance   = 1'b0;
        timeout_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            count_d[c]  = count_q[c];
            shadow_d[c] = shadow_q[c];
            lim_in      = bus.i_limit[c*CNT_W +: CNT_W];
            lim_eff     = shadow_q[c];
            cnt_inc     = count_q[c];
            advance     = 1'b0;

            if (!bus.i_en[c]) begin
                state_d[c] = StIdle;
                count_d[c] = '0;
            end else begin
                unique case (state_q[c])
                    StIdle: begin
                        // Start edge counts as the first tick and ignores hold.
                        advance = 1'b1;
                        cnt_inc = CntOne;
                        lim_eff = lim_in;
                    end
                    StRun: begin
                        if (!bus.i_hold[c]) begin
                            advance = 1'b1;
                            // Saturation only matters for limit 0 (never expires).
                            cnt_inc = (count_q[c] == CntMax) ? count_q[c] : count_q[c] + 1'b1;
                        end
                    end
                    StExpired: begin
                        timeout_d[c] = 1'b1;
                    end
                    default: begin
                        state_d[c] = StIdle;
                        count_d[c] = '0;
                    end
                endcase

                if (advance) begin
                    if (lim_eff != '0 && cnt_inc == lim_eff) begin
                        timeout_d[c] = 1'b1;
                        if (STICKY_MASK[c]) begin
                            state_d[c]  = StExpired;
                            count_d[c]  = lim_eff;
                            shadow_d[c] = lim_eff;
                        end else begin
                            state_d[c]  = StRun;
                            count_d[c]  = '0;
                            shadow_d[c] = lim_in;
                        end
                    end else begin
                        state_d[c]  = StRun;
                        count_d[c]  = cnt_inc;
                        shadow_d[c] = lim_eff;
                    end
                end
            end
        end
    end

    // Outputs, all from registered state.
    always_comb begin
        bus.o_busy        = '0;
        bus.o_count       = '0;
        bus.o_timeout     = timeout_q;
        bus.o_timeout_any = |timeout_q;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.o_busy[c]                  = (state_q[c] == StRun);
            bus.o_count[c*CNT_W +: CNT_W]  = count_q[c];
        end
    end

endmodule

// File: tb/tb_rdi_multi_timer.sv
// Bench for rdi_multi_timer: edge-level behavioural model checked every negedge, plus
// directed scenarios with literal expectations on pulse timing, hold, limit reload,
// saturation, sticky latch, clear-on-expiry and asynchronous reset.
module tb_rdi_multi_timer;
    localparam int              NUM_CH = 2;
    localparam int              CNT_W  = 12;
    localparam logic [1:0]      STICKY = 2'b10;
    localparam int              SAT    = 4095;

    logic lclk    = 1'b0;
    logic sys_rst = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    rdi_multi_timer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    rdi_multi_timer #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .STICKY_MASK (STICKY)
    ) dut (
        .lclk    (lclk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 lclk = ~lclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per channel, number of counted edges since (re)start, limit in force,
    // whether running, whether latched, and the timeout seen after the last edge.
    int m_ticks [NUM_CH];
    int m_lim   [NUM_CH];
    bit m_run   [NUM_CH];
    bit m_lat   [NUM_CH];
    bit m_to    [NUM_CH];

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_ticks[c] = 0; m_lim[c] = 0; m_run[c] = 0; m_lat[c] = 0; m_to[c] = 0;
        end
    end

    always @(posedge lclk or posedge sys_rst) begin
        for (int c = 0; c < NUM_CH; c++) begin
            int lnow;
            bit counted;
            lnow    = int'(bus.i_limit[c*CNT_W +: CNT_W]);
            counted = 1'b1;
            if (sys_rst || !bus.i_en[c]) begin
                m_ticks[c] = 0; m_lim[c] = 0; m_run[c] = 0; m_lat[c] = 0; m_to[c] = 0;
                if (!sys_rst) m_lim[c] = m_lim[c];
            end else if (m_lat[c]) begin
                m_to[c] = 1;
            end else begin
                if (!m_run[c]) begin
                    m_run[c]   = 1;
                    m_lim[c]   = lnow;
                    m_ticks[c] = 1;
                end else if (bus.i_hold[c]) begin
                    counted = 1'b0;
                end else begin
                    m_ticks[c]++;
                end
                m_to[c] = 0;
                if (counted && m_lim[c] != 0 && m_ticks[c] == m_lim[c]) begin
                    m_to[c] = 1;
                    if (STICKY[c]) begin
                        m_lat[c] = 1;
                        m_run[c] = 0;
                    end else begin
                        m_ticks[c] = 0;
                        m_lim[c]   = lnow;
                    end
                end
            end
        end
    end

    // Compare process: outputs are registered, so every negedge is meaningful.
    always @(negedge lclk) begin
        logic [NUM_CH-1:0] et;
        et = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            et[c] = m_to[c];
            check($sformatf("model_timeout[%0d]", c), 32'(bus.o_timeout[c]), 32'(m_to[c]));
            check($sformatf("model_busy[%0d]", c), 32'(bus.o_busy[c]), 32'(m_run[c]));
            check($sformatf("model_count[%0d]", c), 32'(bus.o_count[c*CNT_W +: CNT_W]),
                  32'((m_ticks[c] > SAT) ? SAT : m_ticks[c]));
        end
        check("model_timeout_any", 32'(bus.o_timeout_any), 32'(|et));
    end

    task automatic tick();
        @(posedge lclk);
        #2;
    endtask

    task automatic set_lim(input int c, input int v);
        bus.i_limit[c*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    function automatic int cnt(input int c);
        return int'(bus.o_count[c*CNT_W +: CNT_W]);
    endfunction

    initial begin
        int npulse;
        int first;
        int second;
        int ones;
        bus.i_en    = '0;
        bus.i_hold  = '0;
        bus.i_limit = '0;
        #1 sys_rst = 1'b1;
        tick();
        check("reset_timeout", 32'(bus.o_timeout), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        check("reset_count", 32'(bus.o_count), 32'd0);
        check("reset_any", 32'(bus.o_timeout_any), 32'd0);
        tick();
        sys_rst = 1'b0;
        tick();

        // Ch0 pulse, limit 200, enabled 450 edges.
        set_lim(0, 200);
        bus.i_en[0] = 1'b1;
        npulse = 0; first = 0; second = 0;
        for (int k = 1; k <= 450; k++) begin
            tick();
            if (bus.o_timeout[0]) begin
                npulse++;
                if (npulse == 1) first = k;
                else if (npulse == 2) second = k;
            end
        end
        check("pulse_first", first, 200);
        check("pulse_second", second, 400);
        check("pulse_count", npulse, 2);
        bus.i_en[0] = 1'b0;
        tick();
        check("pulse_clear_busy", 32'(bus.o_busy[0]), 32'd0);

        // Ch1 sticky, limit 1600, enabled 1700 edges.
        set_lim(1, 1600);
        bus.i_en[1] = 1'b1;
        first = 0; ones = 0;
        for (int k = 1; k <= 1700; k++) begin
            tick();
            if (bus.o_timeout[1]) begin
                ones++;
                if (first == 0) first = k;
            end
        end
        check("sticky_rise", first, 1600);
        check("sticky_ones", ones, 101);
        check("sticky_busy", 32'(bus.o_busy[1]), 32'd0);
        check("sticky_count", cnt(1), 1600);
        bus.i_en[1] = 1'b0;
        tick();
        check("sticky_drop", 32'(bus.o_timeout[1]), 32'd0);

        // Ch0 limit 10, hold 5 edges after count reaches 4.
        set_lim(0, 10);
        bus.i_en[0] = 1'b1;
        repeat (4) tick();
        check("hold_pre_count", cnt(0), 4);
        bus.i_hold[0] = 1'b1;
        repeat (5) tick();
        check("hold_frozen_count", cnt(0), 4);
        check("hold_busy", 32'(bus.o_busy[0]), 32'd1);
        bus.i_hold[0] = 1'b0;
        first = 0;
        for (int k = 10; k <= 20; k++) begin
            tick();
            if (bus.o_timeout[0] && first == 0) first = k;
        end
        check("hold_pulse_at", first, 15);
        bus.i_en[0] = 1'b0;
        tick();

        // Limit 10 -> 3 mid-run on pulse channel.
        set_lim(0, 10);
        bus.i_en[0] = 1'b1;
        tick();
        tick();
        set_lim(0, 3);
        first = 0; second = 0; npulse = 0;
        for (int k = 3; k <= 14; k++) begin
            tick();
            if (bus.o_timeout[0]) begin
                npulse++;
                if (npulse == 1) first = k;
                else if (npulse == 2) second = k;
            end
        end
        check("reload_first", first, 10);
        check("reload_second", second, 13);
        bus.i_en[0] = 1'b0;
        tick();

        // Limit 0: never expires, count saturates.
        set_lim(0, 0);
        bus.i_en[0] = 1'b1;
        npulse = 0;
        for (int k = 1; k <= 5000; k++) begin
            tick();
            if (bus.o_timeout[0]) npulse++;
        end
        check("zero_no_timeout", npulse, 0);
        check("zero_saturate", cnt(0), SAT);
        check("zero_busy", 32'(bus.o_busy[0]), 32'd1);
        bus.i_en[0] = 1'b0;
        tick();

        // Limit 1: pulse right after enable edge.
        set_lim(0, 1);
        bus.i_en[0] = 1'b1;
        tick();
        check("lim1_pulse", 32'(bus.o_timeout[0]), 32'd1);
        check("lim1_busy", 32'(bus.o_busy[0]), 32'd1);
        bus.i_en[0] = 1'b0;
        tick();

        // Simultaneous expiry on both channels.
        set_lim(0, 7);
        set_lim(1, 7);
        bus.i_en = 2'b11;
        repeat (7) tick();
        check("both_timeout", 32'(bus.o_timeout), 32'd3);
        check("both_any", 32'(bus.o_timeout_any), 32'd1);
        bus.i_en = 2'b00;
        tick();

        // Enable drops on the would-be expiry edge.
        set_lim(0, 5);
        set_lim(1, 5);
        bus.i_en = 2'b11;
        repeat (4) tick();
        bus.i_en = 2'b00;
        tick();
        check("drop_timeout", 32'(bus.o_timeout), 32'd0);
        check("drop_count", 32'(bus.o_count), 32'd0);

        // Asynchronous reset mid-run.
        bus.i_en = 2'b01;
        repeat (4) tick();
        sys_rst = 1'b1;
        #1;
        check("rst_timeout", 32'(bus.o_timeout), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        tick();
        check("rst_no_pulse", 32'(bus.o_timeout_any), 32'd0);
        bus.i_en = 2'b00;
        sys_rst  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
